// File: rtl/raster_pkg.sv
// Shared definitions for the tile rasteriser.
//   - DEF_* : default coordinate width and tile window
//   - edge_w(): width of edge/area values for a given coordinate width
//   - state_t: rasteriser state encoding
package raster_pkg;

    localparam int DEF_COORD_W = 16;
    localparam int DEF_TILE_X  = 0;
    localparam int DEF_TILE_Y  = 0;
    localparam int DEF_TILE_W  = 320;
    localparam int DEF_TILE_H  = 240;

    // Product of two (COORD_W+1)-bit differences, then one more bit for the subtraction.
    function automatic int edge_w(input int coord_w);
        return 2 * coord_w + 3;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CLIP,
        ST_INIT,
        ST_SCAN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/raster_edge_stepper.sv
// One triangle edge function e(p) = (b.x-a.x)*(p.y-a.y) - (b.y-a.y)*(p.x-a.x).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   load, neg       : evaluate at origin p (multiply only here), negate when neg
//   step_x          : advance one pixel right
//   step_row        : return to row start and advance one row down
//   a_*, b_*, p_*   : edge endpoints and scan origin
//   value           : current sign-normalised edge value
module raster_edge_stepper
    import raster_pkg::*;
#(
    parameter int  COORD_W = DEF_COORD_W,
    localparam int EDGE_W  = edge_w(COORD_W)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic                      neg,
    input  logic                      step_x,
    input  logic                      step_row,
    input  logic signed [COORD_W-1:0] a_x,
    input  logic signed [COORD_W-1:0] a_y,
    input  logic signed [COORD_W-1:0] b_x,
    input  logic signed [COORD_W-1:0] b_y,
    input  logic signed [COORD_W-1:0] p_x,
    input  logic signed [COORD_W-1:0] p_y,
    output logic signed [EDGE_W-1:0]  value
);

    logic signed [EDGE_W-1:0] dx, dy, rel_x, rel_y, e_origin;
    logic signed [EDGE_W-1:0] row_start, inc_x, inc_row;

    assign dx       = EDGE_W'(b_x) - EDGE_W'(a_x);
    assign dy       = EDGE_W'(b_y) - EDGE_W'(a_y);
    assign rel_x    = EDGE_W'(p_x) - EDGE_W'(a_x);
    assign rel_y    = EDGE_W'(p_y) - EDGE_W'(a_y);
    assign e_origin = dx * rel_y - dy * rel_x;

    // Increments are pre-negated at load so stepping is add-only.
    always_ff @(posedge clk) begin
        if (reset) begin
            value     <= '0;
            row_start <= '0;
            inc_x     <= '0;
            inc_row   <= '0;
        end else if (load) begin
            value     <= neg ? -e_origin : e_origin;
            row_start <= neg ? -e_origin : e_origin;
            inc_x     <= neg ? dy : -dy;
            inc_row   <= neg ? -dx : dx;
        end else if (step_row) begin
            value     <= row_start + inc_row;
            row_start <= row_start + inc_row;
        end else if (step_x) begin
            value     <= value + inc_x;
        end
    end

endmodule

// File: rtl/tile_raster_engine.sv
// Edge-function triangle rasteriser for one screen tile.
// Optional feature: define TILE_RASTER_CULL_EN to reject negative-area triangles.
// Ports:
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_draw, i_vN_x/i_vN_y   : start request and vertices (latched when idle)
//   o_busy, o_done          : not-idle flag, one-cycle completion pulse
//   o_valid, i_ready        : covered-pixel handshake
//   o_x, o_y                : covered pixel coordinate
//   o_w1..o_w3, o_area      : sign-normalised edge values and triangle area
module tile_raster_engine
    import raster_pkg::*;
#(
    parameter int  COORD_W = DEF_COORD_W,
    parameter int  TILE_X  = DEF_TILE_X,
    parameter int  TILE_Y  = DEF_TILE_Y,
    parameter int  TILE_W  = DEF_TILE_W,
    parameter int  TILE_H  = DEF_TILE_H,
    localparam int EDGE_W  = edge_w(COORD_W)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_draw,
    input  logic signed [COORD_W-1:0] i_v1_x,
    input  logic signed [COORD_W-1:0] i_v1_y,
    input  logic signed [COORD_W-1:0] i_v2_x,
    input  logic signed [COORD_W-1:0] i_v2_y,
    input  logic signed [COORD_W-1:0] i_v3_x,
    input  logic signed [COORD_W-1:0] i_v3_y,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic signed [COORD_W-1:0] o_x,
    output logic signed [COORD_W-1:0] o_y,
    output logic signed [EDGE_W-1:0]  o_w1,
    output logic signed [EDGE_W-1:0]  o_w2,
    output logic signed [EDGE_W-1:0]  o_w3,
    output logic signed [EDGE_W-1:0]  o_area
);

    localparam logic signed [COORD_W-1:0] TX0 = COORD_W'(TILE_X);
    localparam logic signed [COORD_W-1:0] TX1 = COORD_W'(TILE_X + TILE_W - 1);
    localparam logic signed [COORD_W-1:0] TY0 = COORD_W'(TILE_Y);
    localparam logic signed [COORD_W-1:0] TY1 = COORD_W'(TILE_Y + TILE_H - 1);

    function automatic logic signed [COORD_W-1:0] min2(input logic signed [COORD_W-1:0] a,
                                                       input logic signed [COORD_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic signed [COORD_W-1:0] max2(input logic signed [COORD_W-1:0] a,
                                                       input logic signed [COORD_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t                    state;
    logic signed [COORD_W-1:0] v1x, v1y, v2x, v2y, v3x, v3y;
    logic signed [COORD_W-1:0] bx0, bx1, by0, by1;   // bbox, clipped in place during CLIP
    logic signed [COORD_W-1:0] px, py;               // scan position
    logic signed [EDGE_W-1:0]  area;                 // |area|
    logic                      neg;
    logic                      scan_end;             // last position already evaluated

    logic signed [EDGE_W-1:0]  d21x, d21y, d31x, d31y, area_raw;
    logic signed [COORD_W-1:0] cx0, cx1, cy0, cy1;
    logic                      empty, cull, stall, adv, row_end, step_x, step_row, covered;
    logic signed [EDGE_W-1:0]  w1, w2, w3;

    assign d21x     = EDGE_W'(v2x) - EDGE_W'(v1x);
    assign d21y     = EDGE_W'(v2y) - EDGE_W'(v1y);
    assign d31x     = EDGE_W'(v3x) - EDGE_W'(v1x);
    assign d31y     = EDGE_W'(v3y) - EDGE_W'(v1y);
    assign area_raw = d21x * d31y - d21y * d31x;

    assign cx0   = max2(bx0, TX0);
    assign cx1   = min2(bx1, TX1);
    assign cy0   = max2(by0, TY0);
    assign cy1   = min2(by1, TY1);
    assign empty = (cx0 > cx1) || (cy0 > cy1);

`ifdef TILE_RASTER_CULL_EN
    assign cull = neg;
`else
    assign cull = 1'b0;
`endif

    // A pending pixel that is not accepted freezes the scan and the steppers.
    assign stall    = o_valid && !i_ready;
    assign adv      = (state == ST_SCAN) && !stall && !scan_end;
    assign row_end  = (px == bx1);
    assign step_row = adv && row_end;
    assign step_x   = adv && !row_end;
    assign covered  = !w1[EDGE_W-1] && !w2[EDGE_W-1] && !w3[EDGE_W-1];

    raster_edge_stepper #(.COORD_W(COORD_W)) u_e1 (
        .clk(i_clk), .reset(i_reset), .load(state == ST_INIT), .neg(neg),
        .step_x(step_x), .step_row(step_row),
        .a_x(v2x), .a_y(v2y), .b_x(v3x), .b_y(v3y), .p_x(bx0), .p_y(by0), .value(w1)
    );

    raster_edge_stepper #(.COORD_W(COORD_W)) u_e2 (
        .clk(i_clk), .reset(i_reset), .load(state == ST_INIT), .neg(neg),
        .step_x(step_x), .step_row(step_row),
        .a_x(v3x), .a_y(v3y), .b_x(v1x), .b_y(v1y), .p_x(bx0), .p_y(by0), .value(w2)
    );

    raster_edge_stepper #(.COORD_W(COORD_W)) u_e3 (
        .clk(i_clk), .reset(i_reset), .load(state == ST_INIT), .neg(neg),
        .step_x(step_x), .step_row(step_row),
        .a_x(v1x), .a_y(v1y), .b_x(v2x), .b_y(v2y), .p_x(bx0), .p_y(by0), .value(w3)
    );

    // Control FSM with registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_valid  <= 1'b0;
            o_x      <= '0;
            o_y      <= '0;
            o_w1     <= '0;
            o_w2     <= '0;
            o_w3     <= '0;
            o_area   <= '0;
            v1x      <= '0;
            v1y      <= '0;
            v2x      <= '0;
            v2y      <= '0;
            v3x      <= '0;
            v3y      <= '0;
            bx0      <= '0;
            bx1      <= '0;
            by0      <= '0;
            by1      <= '0;
            px       <= '0;
            py       <= '0;
            area     <= '0;
            neg      <= 1'b0;
            scan_end <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_draw) begin
                        v1x      <= i_v1_x;
                        v1y      <= i_v1_y;
                        v2x      <= i_v2_x;
                        v2y      <= i_v2_y;
                        v3x      <= i_v3_x;
                        v3y      <= i_v3_y;
                        scan_end <= 1'b0;
                        o_busy   <= 1'b1;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    bx0   <= min2(v1x, min2(v2x, v3x));
                    bx1   <= max2(v1x, max2(v2x, v3x));
                    by0   <= min2(v1y, min2(v2y, v3y));
                    by1   <= max2(v1y, max2(v2y, v3y));
                    area  <= area_raw[EDGE_W-1] ? -area_raw : area_raw;
                    neg   <= area_raw[EDGE_W-1];
                    state <= ST_CLIP;
                end
                ST_CLIP: begin
                    bx0 <= cx0;
                    bx1 <= cx1;
                    by0 <= cy0;
                    by1 <= cy1;
                    px  <= cx0;
                    py  <= cy0;
                    if ((area == '0) || empty || cull) begin
                        o_done <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        state  <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (!stall) begin
                        if (scan_end) begin
                            o_valid <= 1'b0;
                            o_done  <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            o_valid <= covered;
                            if (covered) begin
                                o_x    <= px;
                                o_y    <= py;
                                o_w1   <= w1;
                                o_w2   <= w2;
                                o_w3   <= w3;
                                o_area <= area;
                            end
                            if (row_end) begin
                                px <= bx0;
                                py <= py + COORD_W'(1);
                                if (py == by1) scan_end <= 1'b1;
                            end else begin
                                px <= px + COORD_W'(1);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_raster_engine.sv
// Self-checking bench for tile_raster_engine: directed table, handshake and
// reset corner cases, and random triangles against a per-pixel reference model.
module tb_tile_raster_engine;

    localparam int CW     = 16;
    localparam int EW     = 2 * CW + 3;
    localparam int TW     = 320;
    localparam int TH     = 240;
    localparam int BUDGET = 4000;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 draw = 1'b0;
    logic                 ready = 1'b1;
    logic signed [CW-1:0] v1x = '0, v1y = '0, v2x = '0, v2y = '0, v3x = '0, v3y = '0;
    logic                 busy, done, valid;
    logic signed [CW-1:0] ox, oy;
    logic signed [EW-1:0] w1, w2, w3, area;

    int n_tests = 0;
    int n_fail  = 0;

    tile_raster_engine dut (
        .i_clk(clk), .i_reset(rst), .i_draw(draw),
        .i_v1_x(v1x), .i_v1_y(v1y), .i_v2_x(v2x), .i_v2_y(v2y), .i_v3_x(v3x), .i_v3_y(v3y),
        .o_busy(busy), .o_done(done), .o_valid(valid), .i_ready(ready),
        .o_x(ox), .o_y(oy), .o_w1(w1), .o_w2(w2), .o_w3(w3), .o_area(area)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     x;
        int     y;
        longint w1;
        longint w2;
        longint w3;
        longint area;
    } pix_t;

    typedef struct {
        string  name;
        int     x1, y1, x2, y2, x3, y3;
        int     exp_n;      // -1: rely on model only
        int     exp_lat;    // -1: no latency check
        longint exp_area;   // -1: no area check
        int     done_max;   // -1: no done-latency check
    } vec_t;

    pix_t exp_q[$];

    function automatic void check(input bit ok, input string what, input string detail);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: %s", what, detail);
        end
    endfunction

    function automatic longint edge_fn(input longint ax, ay, bx, by, x, y);
        return (bx - ax) * (y - ay) - (by - ay) * (x - ax);
    endfunction

    // Reference: every tile pixel inside the triangle's bbox, row-major, inclusive edges.
    task automatic model(input int x1, y1, x2, y2, x3, y3);
        longint a, s;
        int     xl, xh, yl, yh;
        pix_t   p;
        exp_q.delete();
        a = edge_fn(x1, y1, x2, y2, x3, y3);
        if (a == 0) return;
`ifdef TILE_RASTER_CULL_EN
        if (a < 0) return;
`endif
        s  = (a < 0) ? -1 : 1;
        xl = (x1 < x2) ? x1 : x2;  xl = (xl < x3) ? xl : x3;
        xh = (x1 > x2) ? x1 : x2;  xh = (xh > x3) ? xh : x3;
        yl = (y1 < y2) ? y1 : y2;  yl = (yl < y3) ? yl : y3;
        yh = (y1 > y2) ? y1 : y2;  yh = (yh > y3) ? yh : y3;
        if (xl < 0) xl = 0;
        if (yl < 0) yl = 0;
        if (xh > TW - 1) xh = TW - 1;
        if (yh > TH - 1) yh = TH - 1;
        for (int y = yl; y <= yh; y++) begin
            for (int x = xl; x <= xh; x++) begin
                p.x    = x;
                p.y    = y;
                p.w1   = s * edge_fn(x2, y2, x3, y3, x, y);
                p.w2   = s * edge_fn(x3, y3, x1, y1, x, y);
                p.w3   = s * edge_fn(x1, y1, x2, y2, x, y);
                p.area = s * a;
                if (p.w1 >= 0 && p.w2 >= 0 && p.w3 >= 0) exp_q.push_back(p);
            end
        end
    endtask

    // rmode: 0 ready high, 1 random ready, 2 ready low for the first 3 valid cycles.
    // junk: keep i_draw high with different vertices while busy.
    task automatic run_tri(input vec_t v, input int rmode, input bit junk);
        int   cyc, got, first_lat, done_cyc, stall_cnt;
        bit   fin, rdy, prev_stall;
        logic signed [CW-1:0] hx, hy;
        logic signed [EW-1:0] h1, h2, h3, ha;
        longint first_area;
        model(v.x1, v.y1, v.x2, v.y2, v.x3, v.y3);
        @(negedge clk);
        v1x = CW'(v.x1); v1y = CW'(v.y1); v2x = CW'(v.x2);
        v2y = CW'(v.y2); v3x = CW'(v.x3); v3y = CW'(v.y3);
        draw = 1'b1; ready = 1'b1;
        @(negedge clk);
        if (junk) begin
            v1x = '0; v1y = '0; v2x = CW'(9); v2y = '0; v3x = '0; v3y = CW'(9);
        end else begin
            draw = 1'b0;
        end
        cyc = 1; got = 0; first_lat = -1; done_cyc = -1; stall_cnt = 0;
        fin = 1'b0; prev_stall = 1'b0; first_area = -1;
        hx = '0; hy = '0; h1 = '0; h2 = '0; h3 = '0; ha = '0;
        while (!fin && cyc < BUDGET) begin
            if (prev_stall)
                check(valid && ox == hx && oy == hy && w1 == h1 && w2 == h2 && w3 == h3 && area == ha,
                      {v.name, " hold"},
                      $sformatf("cyc %0d got v=%0b (%0d,%0d) want held (%0d,%0d)", cyc, valid, ox, oy, hx, hy));
            if (done) begin
                fin = 1'b1;
                done_cyc = cyc;
                draw = 1'b0;
                check(!valid, {v.name, " done_no_valid"}, "o_valid high with o_done, want low");
            end else begin
                case (rmode)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 3) != 0);
                    default: begin
                        rdy = !(valid && stall_cnt < 3);
                        if (!rdy) stall_cnt++;
                    end
                endcase
                ready = rdy;
                if (valid) begin
                    if (first_lat < 0) begin
                        first_lat  = cyc;
                        first_area = longint'(area);
                    end
                    if (rdy) begin
                        if (got < exp_q.size())
                            check(int'(ox) == exp_q[got].x && int'(oy) == exp_q[got].y &&
                                  w1 == EW'(exp_q[got].w1) && w2 == EW'(exp_q[got].w2) &&
                                  w3 == EW'(exp_q[got].w3) && area == EW'(exp_q[got].area),
                                  {v.name, " pixel"},
                                  $sformatf("#%0d got (%0d,%0d) w=%0d,%0d,%0d a=%0d want (%0d,%0d) w=%0d,%0d,%0d a=%0d",
                                            got, ox, oy, w1, w2, w3, area, exp_q[got].x, exp_q[got].y,
                                            exp_q[got].w1, exp_q[got].w2, exp_q[got].w3, exp_q[got].area));
                        else
                            check(1'b0, {v.name, " extra_pixel"}, $sformatf("got (%0d,%0d) beyond %0d", ox, oy, exp_q.size()));
                        got++;
                    end
                end
                prev_stall = valid && !rdy;
                hx = ox; hy = oy; h1 = w1; h2 = w2; h3 = w3; ha = area;
                @(negedge clk);
                cyc++;
            end
        end
        ready = 1'b1;
        check(fin, {v.name, " timeout"}, $sformatf("no o_done after %0d cycles", cyc));
        check(got == exp_q.size(), {v.name, " count"}, $sformatf("got %0d pixels want %0d", got, exp_q.size()));
        if (v.exp_n >= 0)
            check(got == v.exp_n, {v.name, " count_const"}, $sformatf("got %0d want %0d", got, v.exp_n));
        if (v.exp_lat >= 0)
            check(first_lat == v.exp_lat, {v.name, " latency"}, $sformatf("first valid at %0d want %0d", first_lat, v.exp_lat));
        if (v.exp_area >= 0 && v.exp_n > 0)
            check(first_area == v.exp_area, {v.name, " area"}, $sformatf("got %0d want %0d", first_area, v.exp_area));
        if (v.done_max >= 0)
            check(fin && done_cyc <= v.done_max, {v.name, " done_latency"}, $sformatf("done at %0d want <= %0d", done_cyc, v.done_max));
        @(negedge clk);
        check(!done && !busy, {v.name, " idle_after_done"}, $sformatf("done=%0b busy=%0b want 0,0", done, busy));
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        tbl[0] = '{"ccw_tri",    0, 0, 4, 0, 0, 4, 15, 5, 16, -1};
`ifdef TILE_RASTER_CULL_EN
        tbl[1] = '{"cw_tri",     0, 0, 0, 4, 4, 0, 0, -1, -1, 6};
`else
        tbl[1] = '{"cw_tri",     0, 0, 0, 4, 4, 0, 15, 5, 16, -1};
`endif
        tbl[2] = '{"degenerate", 0, 0, 2, 2, 4, 4, 0, -1, -1, 6};
        tbl[3] = '{"clip_neg",   -2, -2, 6, -2, -2, 6, 15, 5, 64, -1};
        tbl[4] = '{"off_tile",   -10, -10, -5, -10, -10, -5, 0, -1, -1, 6};
        tbl[5] = '{"far_corner", 316, 236, 330, 236, 316, 250, 16, 5, 196, -1};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check(!valid && !done && !busy, "reset_flags", $sformatf("valid=%0b done=%0b busy=%0b", valid, done, busy));
        check(ox == 0 && oy == 0, "reset_xy", $sformatf("(%0d,%0d) want (0,0)", ox, oy));
        check(w1 == 0 && w2 == 0 && w3 == 0 && area == 0, "reset_w", $sformatf("w=%0d,%0d,%0d a=%0d", w1, w2, w3, area));
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) run_tri(tbl[i], 0, 1'b0);

        // Backpressure on the first pixel.
        rv = tbl[0]; rv.name = "stall3";
        run_tri(rv, 2, 1'b0);

        // i_draw held with other vertices while busy must be ignored.
        rv = tbl[0]; rv.name = "draw_busy";
        run_tri(rv, 0, 1'b1);

        // Reset mid-scan, then a fresh triangle.
        @(negedge clk);
        v1x = '0; v1y = '0; v2x = CW'(4); v2y = '0; v3x = '0; v3y = CW'(4);
        draw = 1'b1;
        @(negedge clk);
        draw = 1'b0;
        repeat (7) @(negedge clk);
        check(busy, "mid_scan_busy", $sformatf("busy=%0b want 1", busy));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check(!valid && !busy && !done, "reset_mid_scan",
              $sformatf("valid=%0b busy=%0b done=%0b want 0", valid, busy, done));
        check(ox == 0 && oy == 0 && area == 0, "reset_mid_data", $sformatf("(%0d,%0d) a=%0d", ox, oy, area));
        @(negedge clk);
        rst = 1'b0;
        rv = tbl[3]; rv.name = "after_reset";
        run_tri(rv, 0, 1'b0);

        // Random triangles with random backpressure.
        for (int k = 0; k < 25; k++) begin
            rv.name = $sformatf("rand%0d", k);
            rv.x1 = int'($urandom_range(0, 25)) - 5;  rv.y1 = int'($urandom_range(0, 25)) - 5;
            rv.x2 = int'($urandom_range(0, 25)) - 5;  rv.y2 = int'($urandom_range(0, 25)) - 5;
            rv.x3 = int'($urandom_range(0, 25)) - 5;  rv.y3 = int'($urandom_range(0, 25)) - 5;
            rv.exp_n = -1; rv.exp_lat = -1; rv.exp_area = -1; rv.done_max = -1;
            run_tri(rv, 1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_raster_engine.md
TILE_RASTER_ENGINE -- requirements
Module: tile_raster_engine

Interface
REQ-001 SHALL have parameter COORD_W, default 16: signed vertex/pixel coordinate width.
REQ-002 SHALL have parameter TILE_X, default 0: tile origin x.
REQ-003 SHALL have parameter TILE_Y, default 0: tile origin y.
REQ-004 SHALL have parameter TILE_W, default 320: tile width in pixels.
REQ-005 SHALL have parameter TILE_H, default 240: tile height in pixels.
REQ-006 SHALL have a single clock and a synchronous, active-high reset: i_clk in 1, rising-edge clock; i_reset in 1, synchronous active-high reset.
REQ-007 SHALL have port i_draw, in, 1: start request, sampled only in IDLE.
REQ-008 SHALL have ports i_vN_x / i_vN_y (N=1..3), in, COORD_W each: signed integer vertex coordinates, latched on accepted i_draw.
REQ-009 SHALL have port o_busy, out, 1: high whenever the state is not IDLE.
REQ-010 SHALL have port o_done, out, 1: one-cycle completion pulse.
REQ-011 SHALL have port o_valid, out, 1: pixel output valid.
REQ-012 SHALL have port i_ready, in, 1: downstream accepts the pixel.
REQ-013 SHALL have ports o_x / o_y, out, COORD_W each: covered pixel coordinate.
REQ-014 SHALL have ports o_w1 / o_w2 / o_w3 / o_area, out, EDGE_W = 2*COORD_W+3 each: sign-normalised edge values and area.

Function
REQ-015 SHALL use state sequence IDLE -> SETUP (bbox, area) -> CLIP -> INIT (edge values at bbox origin) -> SCAN -> DONE -> IDLE.
REQ-016 SHALL define edges e1: v2->v3, e2: v3->v1, e3: v1->v2, where e(p) = (b.x-a.x)*(p.y-a.y) - (b.y-a.y)*(p.x-a.x), full EDGE_W precision with no truncation.
REQ-017 SHALL compute area = (v2.x-v1.x)*(v3.y-v1.y) - (v2.y-v1.y)*(v3.x-v1.x).
REQ-018 SHALL, when area<0, negate all edge values and the area before testing and output.
REQ-019 SHALL treat a pixel as covered iff all three normalised edge values are >= 0 (edges inclusive).
REQ-020 SHALL clip the bbox to x in [TILE_X, TILE_X+TILE_W-1] and y in [TILE_Y, TILE_Y+TILE_H-1].
REQ-021 SHALL, when area==0 or the clipped bbox is empty, go directly to DONE with no o_valid.
REQ-022 SHALL scan row-major, x fastest, one position per cycle while not stalled.
REQ-023 SHALL step edges incrementally: x step adds -(b.y-a.y); row step restores the row-start value plus (b.x-a.x); no per-pixel multiply.
REQ-024 SHALL drive a registered output; an uncovered position produces no o_valid.
REQ-025 SHALL hold o_valid and all output data stable while o_valid=1 and i_ready=0, with scanning stalled and no pixel lost or duplicated.
REQ-026 SHALL assert o_valid for the bbox-origin pixel, when covered, exactly 5 cycles after the cycle i_draw is accepted.
REQ-027 SHALL pulse o_done for one cycle in DONE, after the last pixel handshake; o_busy SHALL be low the following cycle.
REQ-028 SHALL ignore i_draw while busy.

Reset
REQ-029 SHALL, on i_reset (including mid-scan), enter IDLE and clear o_valid, o_done, o_busy, and all outputs and latched vertices to 0 on the next edge.

Configuration
REQ-030 SHALL, with TILE_RASTER_CULL_EN defined, treat area<0 triangles as rejected (straight to DONE, no pixels); without it, both windings SHALL rasterise per REQ-018.

Structure
REQ-031 SHALL place EDGE_W derivation, the state encoding and the tile default constants in shared package raster_pkg.
REQ-032 SHALL implement edge evaluation and stepping in sub-module raster_edge_stepper, instantiated three times.

Verification
REQ-033 SHALL test v=(0,0),(4,0),(0,4) with i_ready=1: exactly 15 pixels, all with x+y<=4, first (0,0) 5 cycles after i_draw, o_area=16, then one o_done.
REQ-034 SHALL test v=(0,0),(0,4),(4,0): without the macro the same 15 pixels with o_area=16; with TILE_RASTER_CULL_EN, 0 pixels and o_done.
REQ-035 SHALL test v=(0,0),(2,2),(4,4): 0 pixels, o_done within 6 cycles.
REQ-036 SHALL test v=(-2,-2),(6,-2),(-2,6): clipped to the tile, exactly 15 pixels, first (0,0).
REQ-037 SHALL test REQ-033 stimulus with i_ready held low 3 cycles at the first o_valid: o_x/o_y held at (0,0), 15 pixels total, none duplicated.
REQ-038 SHALL test i_reset for 1 cycle mid-scan: the next cycle has o_valid=0 and o_busy=0, and a new i_draw rasterises correctly.
